// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x DATA_WIDTH registers with byte strobes.
// Define AXIL_REGFILE_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi_lite_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [STRB_WIDTH-1:0]          wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int OFS   = $clog2(STRB_WIDTH);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0] RESP_OOR = 2'b11;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    logic                                 aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0]                aw_addr_q, aw_addr_d;
    logic                                 w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]                w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0]                w_strb_q, w_strb_d;
    logic                                 bvalid_q, bvalid_d;
    logic [1:0]                           bresp_q, bresp_d;
    logic                                 rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]                rdata_q, rdata_d;
    logic [1:0]                           rresp_q, rresp_d;
    logic [NUM_REGS-1:0]                  wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;

    logic             aw_hs, w_hs, ar_hs, commit, wr_hit, rd_hit;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign awready = !rst && !aw_full_q;
    assign wready  = !rst && !w_full_q;
    assign arready = !rst && !rvalid_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    // A held-off B response blocks the next commit; the buffers keep accepting meanwhile.
    assign commit = aw_full_q && w_full_q && (!bvalid_q || bready);

    assign wr_idx = aw_addr_q[OFS +: IDX_W];
    assign wr_hit = aw_addr_q < LIMIT;
    assign rd_idx = araddr[OFS +: IDX_W];
    assign rd_hit = araddr < LIMIT;

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (bvalid_q && bready) bvalid_d = 1'b0;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_hit ? RESP_OKAY : RESP_OOR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit && wr_idx == IDX_W'(i)) begin
                    for (int k = 0; k < STRB_WIDTH; k++)
                        if (w_strb_q[k]) regs_d[i][8*k +: 8] = w_data_q[8*k +: 8];
                    wr_pulse_d[i] = |w_strb_q;
                end
            end
        end

        if (rvalid_q && rready) rvalid_d = 1'b0;
        // Read samples regs_q, so a same-edge commit is not visible in this response.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_OOR;
            rdata_d  = '0;
            for (int i = 0; i < NUM_REGS; i++)
                if (rd_hit && rd_idx == IDX_W'(i)) rdata_d = regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            regs_q     <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign wr_pulse = wr_pulse_q;
    assign regs_o   = regs_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (default parameters, 16 x 32-bit registers).
module tb_axi_lite_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0] EXP_OOR = 2'b11;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    awaddr, araddr;
    logic             awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wstrb;
    logic             awready, wready, bvalid, arready, rvalid;
    logic [1:0]       bresp, rresp;
    logic [DW-1:0]    rdata;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]    wr_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_regs [NR];
    logic [DW-1:0] rd_d;
    logic [1:0]    rd_r;

    always #5 clk = ~clk;

    axi_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_o(regs_o), .wr_pulse(wr_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] reg_of(input int i);
        return regs_o[i*DW +: DW];
    endfunction

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NR; i++) chk(tag, 64'(reg_of(i)), 64'(exp_regs[i]));
    endtask

    // AW+W in the same cycle, commit one edge later, then B accepted.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] s, input logic [1:0] exp_resp,
                            input logic [NR-1:0] exp_pulse);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("wr_bvalid", 64'(bvalid), 64'd1);
        chk("wr_bresp", 64'(bresp), 64'(exp_resp));
        chk("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("rd_rvalid", 64'(rvalid), 64'd1);
        d = rdata; r = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        repeat (3) tick();
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_pulse", 64'(wr_pulse), 64'd0);
        chk("rst_regs_zero", 64'(regs_o == '0), 64'd1);
        rst = 1'b0;
        #1;
        chk("idle_ready", 64'({awready, wready, arready}), 64'b111);

        // AW+W together at 0x8
        awaddr = 32'h8; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_no_early_b", 64'(bvalid), 64'd0);
        tick();
        chk("t1_bvalid", 64'(bvalid), 64'd1);
        chk("t1_bresp", 64'(bresp), 64'd0);
        chk("t1_reg2", 64'(reg_of(2)), 64'hDEADBEEF);
        chk("t1_pulse", 64'(wr_pulse), 64'h0004);
        tick();
        chk("t1_pulse_off", 64'(wr_pulse), 64'h0000);
        chk("t1_b_held", 64'(bvalid), 64'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("t1_b_done", 64'(bvalid), 64'd0);
        exp_regs[2] = 32'hDEADBEEF;

        // W three cycles ahead of AW
        wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("t2_wready_low", 64'(wready), 64'd0);
        tick(); tick();
        chk("t2_no_commit", 64'(bvalid), 64'd0);
        chk("t2_reg1_old", 64'(reg_of(1)), 64'd0);
        awaddr = 32'h4; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("t2_wait_commit", 64'(bvalid), 64'd0);
        tick();
        chk("t2_bvalid", 64'(bvalid), 64'd1);
        chk("t2_reg1", 64'(reg_of(1)), 64'hAA);
        chk("t2_pulse", 64'(wr_pulse), 64'h0002);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        exp_regs[1] = 32'hAA;

        // Read 0x8 with rready held low
        araddr = 32'h8; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t3_rvalid", 64'(rvalid), 64'd1);
            chk("t3_rdata", 64'(rdata), 64'hDEADBEEF);
            chk("t3_arready", 64'(arready), 64'd0);
            tick();
        end
        rready = 1'b1;
        #1;
        chk("t3_rdata_last", 64'(rdata), 64'hDEADBEEF);
        tick();
        rready = 1'b0;
        chk("t3_r_done", 64'(rvalid), 64'd0);
        chk("t3_arready_back", 64'(arready), 64'd1);

        // Partial strobe, zero strobe, unaligned read
        do_write(32'h4, 32'h00550000, 4'h4, 2'b00, 16'h0002);
        exp_regs[1] = 32'h005500AA;
        do_write(32'h8, 32'h12345678, 4'h0, 2'b00, 16'h0000);
        chk_regs("t4_regs");
        do_read(32'h9, rd_d, rd_r);
        chk("t4_unaligned", 64'(rd_d), 64'hDEADBEEF);

        // Out-of-range write and read
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, EXP_OOR, 16'h0000);
        chk_regs("t5_regs");
        do_read(32'h40, rd_d, rd_r);
        chk("t5_rdata", 64'(rd_d), 64'd0);
        chk("t5_rresp", 64'(rd_r), 64'(EXP_OOR));

        // Read and write commit on reg3 at the same edge
        do_write(32'hC, 32'h1, 4'hF, 2'b00, 16'h0008);
        awaddr = 32'hC; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'hC; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("t6_bvalid", 64'(bvalid), 64'd1);
        chk("t6_rdata_old", 64'(rdata), 64'h1);
        chk("t6_reg3_new", 64'(reg_of(3)), 64'h2);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        do_read(32'hC, rd_d, rd_r);
        chk("t6_rdata_new", 64'(rd_d), 64'h2);

        // Second write stalls behind unaccepted B, then reset
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h11; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        tick();
        chk("t7_first_b", 64'(bvalid), 64'd1);
        awaddr = 32'h14; wdata = 32'h22;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t7_bufs_full", 64'({awready, wready}), 64'b00);
        tick();
        chk("t7_reg5_waiting", 64'(reg_of(5)), 64'd0);
        chk("t7_reg4", 64'(reg_of(4)), 64'h11);
        chk("t7_no_pulse", 64'(wr_pulse), 64'd0);
        rst = 1'b1;
        tick();
        chk("t7_rst_bvalid", 64'(bvalid), 64'd0);
        chk("t7_rst_bresp", 64'(bresp), 64'd0);
        chk("t7_rst_rvalid", 64'(rvalid), 64'd0);
        chk("t7_rst_rdata", 64'(rdata), 64'd0);
        chk("t7_rst_pulse", 64'(wr_pulse), 64'd0);
        chk("t7_rst_regs_zero", 64'(regs_o == '0), 64'd1);
        rst = 1'b0;
        bready = 1'b1;
        tick(); tick();
        bready = 1'b0;
        chk("t7_dropped", 64'(bvalid), 64'd0);
        chk("t7_regs_still_zero", 64'(regs_o == '0), 64'd1);
        chk("t7_ready_again", 64'({awready, wready, arready}), 64'b111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
